rom_seq_ctrl: RTL and testbench
===============================

Name: rom_seq_ctrl

Overview:
- Sequencer for the pattern-ROM → LED datapath in the SOC top.
- Walks a programmable address window of a synchronous-read ROM, latches each word into the LED register and holds it for a programmable dwell time.
- Supports one-shot or looping playback.
- Replaces the free-running PC with a start/stop/busy/done-controlled engine.

Parameters:
AW, 5, ROM address width
DW, 5, ROM data / LED width
DWELL_W, 27, dwell counter width

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous active-high reset
start  in  1  start pulse; sampled in IDLE only
stop  in  1  abort request; highest priority
first_addr  in  AW  first window address
last_addr  in  AW  last window address
loop_en  in  1  1 = restart at first_addr after last_addr
pingpong  in  1  bounce mode; honoured only under SEQ_PINGPONG_EN
dwell  in  DWELL_W  hold cycles per step, minus one
rom_rd  out  1  ROM read strobe
rom_addr  out  AW  ROM address
rom_data  in  DW  ROM read data, valid the cycle after rom_rd
leds  out  DW  latched pattern
pc  out  AW  current step address
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse on natural completion

Behaviour:
- Clock and reset: one clock, CLK. Reset is RESET: synchronous, active-high.
- Reset values: state=IDLE, leds=0, pc=0, rom_rd=0, rom_addr=0, busy=0, done=0, dwell counter=0, direction=up.
- Reset mid-operation gives the same result; the sequence is abandoned.
- States: IDLE, FETCH, LATCH, DWELL.
- IDLE:
  - start=1 and stop=0 at edge N: shadow-capture first_addr, last_addr, loop_en, pingpong, dwell; pc←first_addr; go to FETCH.
  - busy=1 from cycle N+1.
- FETCH (1 cycle): rom_rd=1, rom_addr=pc; go to LATCH.
- LATCH (1 cycle):
  - leds←rom_data (visible the next cycle).
  - Dwell counter←shadow dwell; go to DWELL.
- DWELL:
  - Counter decrements each cycle. Leaving DWELL happens in the cycle the counter reads 0.
  - Step period is exactly dwell+3 cycles.
- Advance at the end of DWELL:
  - pc≠last: pc←pc+1 modulo 2^AW, go to FETCH.
  - pc=last and loop_en=1: pc←first, go to FETCH.
  - pc=last and loop_en=0: done=1 for one cycle, go to IDLE. leds and pc hold.
- Window wrap: first_addr>last_addr is legal; pc wraps through 2^AW−1 to 0. first==last gives a single-step window.
- stop:
  - In any non-IDLE state, stop=1 forces IDLE next cycle. No done pulse; leds hold their last value; rom_rd deasserts.
  - stop wins over simultaneous start.
- start while busy is ignored.
- Config inputs may change while busy; they take effect only at the next start.
- rom_rd is high only in FETCH; rom_addr equals pc whenever rom_rd=1.
- Configuration ignored by the sequencer: dwell=0 is legal (3-cycle step). Live window inputs are not used while busy.

Optional Feature:
- Macro: SEQ_PINGPONG_EN.
- Defined, and shadow pingpong=1:
  - A direction flag controls stepping. While up, reaching last reverses direction and steps to pc−1. While down, reaching first either reverses (loop_en=1) or ends with a done pulse (loop_en=0).
  - Endpoints are not fetched twice per bounce. first==last behaves as the normal single-step window.
- Not defined: the pingpong port is present but ignored; direction logic is not synthesised; behaviour is always up-counting.

Test Plan:
- Reset, then first=0, last=3, loop_en=0, dwell=1, start pulse; ROM[i]=i → leds=0,1,2,3 each held 4 cycles; done pulses once, 1 cycle after last DWELL; busy then low; leds=3 held.
- first=2, last=4, loop_en=1, dwell=0 → rom_addr sequence 2,3,4,2,3,4…; rom_rd period 3 cycles; done never asserts.
- first=30, last=1 (AW=5), loop_en=0 → pc visits 30,31,0,1 then done.
- Mid-DWELL stop=1 at step pc=5 → IDLE next cycle; busy=0, done=0, leds unchanged. Assert RESET during FETCH → leds=0, pc=0, rom_rd=0 next cycle.
- start and stop in the same IDLE cycle → stays IDLE. start while busy is ignored, so pc continues the original window. dwell input changed while busy → step period unchanged.
- With SEQ_PINGPONG_EN: first=1, last=3, pingpong=1, loop_en=0 → pc 1,2,3,2,1 then done. Without the macro the same stimulus gives 1,2,3 then done.

Source files
------------

// File: rtl/rom_seq_ctrl.sv
// Sequencer that walks an address window of a synchronous-read pattern ROM into the LED register.
// Optional bounce (ping-pong) playback is compiled in with SEQ_PINGPONG_EN.
module rom_seq_ctrl #(
    parameter int unsigned AW      = 5,
    parameter int unsigned DW      = 5,
    parameter int unsigned DWELL_W = 27
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic               stop,
    input  logic [AW-1:0]      first_addr,
    input  logic [AW-1:0]      last_addr,
    input  logic               loop_en,
    input  logic               pingpong,
    input  logic [DWELL_W-1:0] dwell,
    output logic               rom_rd,
    output logic [AW-1:0]      rom_addr,
    input  logic [DW-1:0]      rom_data,
    output logic [DW-1:0]      leds,
    output logic [AW-1:0]      pc,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, FETCH, LATCH, DWELL} state_t;

    state_t               state, state_nxt;
    logic [AW-1:0]        pc_nxt, rom_addr_nxt;
    logic [DW-1:0]        leds_nxt;
    logic                 rom_rd_nxt, busy_nxt, done_nxt;
    logic [DWELL_W-1:0]   cnt, cnt_nxt;

    // Configuration shadowed at start so live inputs never disturb a running sequence.
    logic [AW-1:0]        sh_first, sh_first_nxt;
    logic [AW-1:0]        sh_last, sh_last_nxt;
    logic                 sh_loop, sh_loop_nxt;
    logic [DWELL_W-1:0]   sh_dwell, sh_dwell_nxt;

`ifdef SEQ_PINGPONG_EN
    logic                 sh_pp, sh_pp_nxt;
    logic                 dir_down, dir_down_nxt;
`else
    logic                 unused_pingpong;
    assign unused_pingpong = pingpong;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            pc       <= '0;
            leds     <= '0;
            rom_rd   <= 1'b0;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            sh_first <= '0;
            sh_last  <= '0;
            sh_loop  <= 1'b0;
            sh_dwell <= '0;
`ifdef SEQ_PINGPONG_EN
            sh_pp    <= 1'b0;
            dir_down <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            leds     <= leds_nxt;
            rom_rd   <= rom_rd_nxt;
            rom_addr <= rom_addr_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            cnt      <= cnt_nxt;
            sh_first <= sh_first_nxt;
            sh_last  <= sh_last_nxt;
            sh_loop  <= sh_loop_nxt;
            sh_dwell <= sh_dwell_nxt;
`ifdef SEQ_PINGPONG_EN
            sh_pp    <= sh_pp_nxt;
            dir_down <= dir_down_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        leds_nxt     = leds;
        cnt_nxt      = cnt;
        done_nxt     = 1'b0;
        sh_first_nxt = sh_first;
        sh_last_nxt  = sh_last;
        sh_loop_nxt  = sh_loop;
        sh_dwell_nxt = sh_dwell;
`ifdef SEQ_PINGPONG_EN
        sh_pp_nxt    = sh_pp;
        dir_down_nxt = dir_down;
`endif

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    sh_first_nxt = first_addr;
                    sh_last_nxt  = last_addr;
                    sh_loop_nxt  = loop_en;
                    sh_dwell_nxt = dwell;
                    pc_nxt       = first_addr;
                    state_nxt    = FETCH;
`ifdef SEQ_PINGPONG_EN
                    sh_pp_nxt    = pingpong;
                    dir_down_nxt = 1'b0;
`endif
                end
            end
            FETCH: state_nxt = LATCH;
            LATCH: begin
                leds_nxt  = rom_data;
                cnt_nxt   = sh_dwell;
                state_nxt = DWELL;
            end
            DWELL: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - DWELL_W'(1);
                end else begin
                    state_nxt = FETCH;
`ifdef SEQ_PINGPONG_EN
                    if (dir_down) begin
                        if (pc != sh_first) begin
                            pc_nxt = pc - AW'(1);
                        end else if (sh_loop) begin
                            dir_down_nxt = 1'b0;
                            pc_nxt       = pc + AW'(1);
                        end else begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else if (pc == sh_last && sh_pp && sh_first != sh_last) begin
                        // Bounce off the top without refetching the endpoint.
                        dir_down_nxt = 1'b1;
                        pc_nxt       = pc - AW'(1);
                    end else
`endif
                    if (pc != sh_last) begin
                        pc_nxt = pc + AW'(1);
                    end else if (sh_loop) begin
                        pc_nxt = sh_first;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort overrides everything and freezes the visible datapath.
        if (stop && state != IDLE) begin
            state_nxt = IDLE;
            pc_nxt    = pc;
            leds_nxt  = leds;
            cnt_nxt   = cnt;
            done_nxt  = 1'b0;
`ifdef SEQ_PINGPONG_EN
            dir_down_nxt = dir_down;
`endif
        end

        rom_rd_nxt   = (state_nxt == FETCH);
        rom_addr_nxt = rom_rd_nxt ? pc_nxt : rom_addr;
        busy_nxt     = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_rom_seq_ctrl.sv
// Self-checking bench for rom_seq_ctrl: step-list timeline model plus directed literal checks.
module tb_rom_seq_ctrl;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 5;
    localparam int unsigned DWELL_W = 27;
    localparam int AMASK = (1 << AW) - 1;

    logic               CLK = 1'b0;
    logic               RESET;
    logic               start, stop, loop_en, pingpong;
    logic [AW-1:0]      first_addr, last_addr;
    logic [DWELL_W-1:0] dwell;
    logic               rom_rd, busy, done;
    logic [AW-1:0]      rom_addr, pc;
    logic [DW-1:0]      rom_data, leds;

    logic [DW-1:0]      rom [32];

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 0;
    string obs_str = "";
    int busy_cycles = 0;
    int done_cnt = 0;

    rom_seq_ctrl #(.AW(AW), .DW(DW), .DWELL_W(DWELL_W)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .stop(stop),
        .first_addr(first_addr), .last_addr(last_addr), .loop_en(loop_en),
        .pingpong(pingpong), .dwell(dwell), .rom_rd(rom_rd), .rom_addr(rom_addr),
        .rom_data(rom_data), .leds(leds), .pc(pc), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (rom_rd) rom_data <= rom[rom_addr];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got '%s', expected '%s'", name, act, exp);
    endtask

    // Model: a run is a list of step addresses; each step occupies dwell+3 cycles.
    int seq[$];
    bit m_active = 0, m_done = 0, m_loop = 0;
    int m_t = 0, m_per = 3;
    logic [AW-1:0] m_pc = '0;
    logic [DW-1:0] m_leds = '0;

    function automatic void build_seq(input int f, input int l, input bit lp, input bit pp);
        int n;
        bit bounce;
        seq.delete();
        n = ((l - f) & AMASK) + 1;
        for (int i = 0; i < n; i++) seq.push_back((f + i) & AMASK);
        bounce = pp && (n > 1);
`ifndef SEQ_PINGPONG_EN
        bounce = 1'b0;
`endif
        if (bounce)
            for (int i = n - 2; i >= (lp ? 1 : 0); i--) seq.push_back((f + i) & AMASK);
    endfunction

    always @(posedge CLK) begin
        if (RESET) begin
            m_active <= 0; m_done <= 0; m_leds <= '0; m_pc <= '0; m_t <= 0;
        end else if (!m_active) begin
            m_done <= 0;
            if (start && !stop) begin
                build_seq(int'(first_addr), int'(last_addr), loop_en, pingpong);
                m_loop <= loop_en;
                m_per <= int'(dwell) + 3;
                m_active <= 1;
                m_t <= 0;
                m_pc <= first_addr;
            end
        end else if (stop) begin
            m_active <= 0;
            m_done <= 0;
        end else if (!m_loop && (m_t + 1) == seq.size() * m_per) begin
            m_active <= 0;
            m_done <= 1;
        end else begin
            m_t <= m_t + 1;
            if ((m_t + 1) % m_per == 0)
                m_pc <= AW'(seq[((m_t + 1) / m_per) % seq.size()]);
            if ((m_t + 1) % m_per == 2)
                m_leds <= rom[seq[((m_t + 1) / m_per) % seq.size()]];
        end
    end

    function automatic int exp_vec();
        bit rd;
        rd = m_active && (m_t % m_per == 0);
        return int'({m_active, m_done, rd, rd ? m_pc : 5'd0, m_pc, m_leds});
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            check("cycle{busy,done,rd,addr,pc,leds}",
                  int'({busy, done, rom_rd, rom_rd ? rom_addr : 5'd0, pc, leds}), exp_vec());
            if (rom_rd) obs_str = {obs_str, $sformatf("%0d,", rom_addr)};
            if (busy) busy_cycles++;
            if (done) done_cnt++;
        end
    end

    // Leaves the bench at the negedge of the first busy cycle (FETCH of step 0).
    task automatic run(input int f, input int l, input bit lp, input bit pp, input int dw);
        @(negedge CLK);
        obs_str = ""; busy_cycles = 0; done_cnt = 0;
        first_addr = AW'(f); last_addr = AW'(l); loop_en = lp; pingpong = pp;
        dwell = DWELL_W'(dw); start = 1'b1; stop = 1'b0;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy === 1'b1 && n < max) begin
            @(negedge CLK);
            n++;
        end
        check("wait_idle_timeout", int'(n < max), 1);
        @(negedge CLK);
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; start = 0; stop = 0; loop_en = 0; pingpong = 0;
        first_addr = '0; last_addr = '0; dwell = '0;
        for (int i = 0; i < 32; i++) rom[i] = DW'(i);
        repeat (3) @(negedge CLK);
        check("reset_outputs", int'({busy, done, rom_rd, rom_addr, pc, leds}), 0);
        RESET = 1'b0;
        chk_en = 1'b1;

        // One-shot 0..3, dwell=1, identity ROM
        run(0, 3, 0, 0, 1);
        wait_idle(100);
        check_str("oneshot_fetches", obs_str, "0,1,2,3,");
        check("oneshot_busy_cycles", busy_cycles, 16);
        check("oneshot_done_count", done_cnt, 1);
        check("oneshot_leds_hold", int'(leds), 3);

        for (int i = 0; i < 32; i++) rom[i] = DW'(31 - i);

        // Looping 2..4, dwell=0
        run(2, 4, 1, 0, 0);
        repeat (11) @(negedge CLK);
        check_str("loop_fetches", obs_str, "2,3,4,2,");
        stop_pulse();
        check("loop_no_done", done_cnt, 0);

        // Wrapping window 30..1
        run(30, 1, 0, 0, 0);
        wait_idle(100);
        check_str("wrap_fetches", obs_str, "30,31,0,1,");
        check("wrap_done_count", done_cnt, 1);
        check("wrap_pc_hold", int'(pc), 1);

        // Stop in DWELL of the pc=5 step
        run(4, 8, 0, 0, 3);
        repeat (9) @(negedge CLK);
        stop_pulse();
        check("stop_idle", int'({busy, done}), 0);
        check("stop_leds_hold", int'(leds), 26);
        check("stop_pc_hold", int'(pc), 5);

        // Reset during FETCH
        run(6, 9, 1, 0, 2);
        RESET = 1'b1;
        @(negedge CLK);
        check("reset_in_fetch", int'({busy, rom_rd, pc, leds}), 0);
        RESET = 1'b0;

        // Start and stop together in IDLE
        @(negedge CLK);
        first_addr = 5'd3; start = 1'b1; stop = 1'b1;
        @(negedge CLK);
        start = 1'b0; stop = 1'b0;
        check("start_stop_same_cycle", int'({busy, pc}), 0);

        // Start and config changes while busy are ignored
        run(10, 12, 0, 0, 1);
        repeat (2) @(negedge CLK);
        first_addr = 5'd20; last_addr = 5'd21; dwell = DWELL_W'(5); start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_idle(100);
        check_str("busy_start_fetches", obs_str, "10,11,12,");
        check("busy_start_busy_cycles", busy_cycles, 12);

        // Ping-pong request, one-shot then looping
        run(1, 3, 0, 1, 0);
        wait_idle(100);
`ifdef SEQ_PINGPONG_EN
        check_str("pp_oneshot_fetches", obs_str, "1,2,3,2,1,");
        check("pp_oneshot_pc", int'(pc), 1);
`else
        check_str("pp_oneshot_fetches", obs_str, "1,2,3,");
        check("pp_oneshot_pc", int'(pc), 3);
`endif
        run(1, 3, 1, 1, 0);
        repeat (14) @(negedge CLK);
`ifdef SEQ_PINGPONG_EN
        check_str("pp_loop_fetches", obs_str, "1,2,3,2,1,");
`else
        check_str("pp_loop_fetches", obs_str, "1,2,3,1,2,");
`endif
        stop_pulse();
        @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
